// File: rtl/pipe_pkg.sv
// Shared stage-bundle layout for the CPU pipeline registers: widths, field offsets
// and nop reset constants for IF/ID, ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REGA_W = 5;
    localparam int CTRL_W = 16;
    localparam int MUL_W  = 2 * XLEN;
    localparam int OCC_W  = 2;

    // IF/ID: pc, instr
    localparam int IFID_PC_OFF    = 0;
    localparam int IFID_INSTR_OFF = IFID_PC_OFF + XLEN;
    localparam int IFID_W         = IFID_INSTR_OFF + XLEN;

    // ID/EX: pc, instr, rs1/rs2 operands, extended immediate, waddr, control
    localparam int IDEX_PC_OFF    = 0;
    localparam int IDEX_INSTR_OFF = IDEX_PC_OFF + XLEN;
    localparam int IDEX_RS1_OFF   = IDEX_INSTR_OFF + XLEN;
    localparam int IDEX_RS2_OFF   = IDEX_RS1_OFF + XLEN;
    localparam int IDEX_IMM_OFF   = IDEX_RS2_OFF + XLEN;
    localparam int IDEX_WADDR_OFF = IDEX_IMM_OFF + XLEN;
    localparam int IDEX_CTRL_OFF  = IDEX_WADDR_OFF + REGA_W;
    localparam int IDEX_W         = IDEX_CTRL_OFF + CTRL_W;

    // EX/MEM: alu result, store data, waddr, control, pc, instr, imm, multiplier result
    localparam int EXME_ALU_OFF   = 0;
    localparam int EXME_ST_OFF    = EXME_ALU_OFF + XLEN;
    localparam int EXME_WADDR_OFF = EXME_ST_OFF + XLEN;
    localparam int EXME_CTRL_OFF  = EXME_WADDR_OFF + REGA_W;
    localparam int EXME_PC_OFF    = EXME_CTRL_OFF + CTRL_W;
    localparam int EXME_INSTR_OFF = EXME_PC_OFF + XLEN;
    localparam int EXME_IMM_OFF   = EXME_INSTR_OFF + XLEN;
    localparam int EXME_MUL_OFF   = EXME_IMM_OFF + XLEN;
    localparam int EXME_W         = EXME_MUL_OFF + MUL_W;

    // MEM/WB: writeback value, waddr, control, pc, instr
    localparam int MEWB_WB_OFF    = 0;
    localparam int MEWB_WADDR_OFF = MEWB_WB_OFF + XLEN;
    localparam int MEWB_CTRL_OFF  = MEWB_WADDR_OFF + REGA_W;
    localparam int MEWB_PC_OFF    = MEWB_CTRL_OFF + CTRL_W;
    localparam int MEWB_INSTR_OFF = MEWB_PC_OFF + XLEN;
    localparam int MEWB_W         = MEWB_INSTR_OFF + XLEN;

    // An all-zero instruction field decodes as a nop, so zero bundles are bubbles.
    localparam logic [IFID_W-1:0] NOP_BUNDLE_IFID = '0;
    localparam logic [IDEX_W-1:0] NOP_BUNDLE_IDEX = '0;
    localparam logic [EXME_W-1:0] NOP_BUNDLE_EXME = '0;
    localparam logic [MEWB_W-1:0] NOP_BUNDLE_MEWB = '0;

    typedef struct packed {
        logic [MUL_W-1:0]  mul;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   instr;
        logic [XLEN-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [REGA_W-1:0] waddr;
        logic [XLEN-1:0]   st;
        logic [XLEN-1:0]   alu;
    } exme_t;

    function automatic logic [EXME_W-1:0] exme_pack(input exme_t f);
        logic [EXME_W-1:0] b;
        b = NOP_BUNDLE_EXME;
        b[EXME_ALU_OFF   +: XLEN]   = f.alu;
        b[EXME_ST_OFF    +: XLEN]   = f.st;
        b[EXME_WADDR_OFF +: REGA_W] = f.waddr;
        b[EXME_CTRL_OFF  +: CTRL_W] = f.ctrl;
        b[EXME_PC_OFF    +: XLEN]   = f.pc;
        b[EXME_INSTR_OFF +: XLEN]   = f.instr;
        b[EXME_IMM_OFF   +: XLEN]   = f.imm;
        b[EXME_MUL_OFF   +: MUL_W]  = f.mul;
        return b;
    endfunction

    function automatic exme_t exme_unpack(input logic [EXME_W-1:0] b);
        exme_t f;
        f.alu   = b[EXME_ALU_OFF   +: XLEN];
        f.st    = b[EXME_ST_OFF    +: XLEN];
        f.waddr = b[EXME_WADDR_OFF +: REGA_W];
        f.ctrl  = b[EXME_CTRL_OFF  +: CTRL_W];
        f.pc    = b[EXME_PC_OFF    +: XLEN];
        f.instr = b[EXME_INSTR_OFF +: XLEN];
        f.imm   = b[EXME_IMM_OFF   +: XLEN];
        f.mul   = b[EXME_MUL_OFF   +: MUL_W];
        return f;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Single valid+data holding entry. Reset and clear both restore RESET_VALUE;
// load takes priority over drop so a same-cycle refill keeps the entry valid.
module pipe_skid_slot #(
    parameter int               WIDTH       = 200,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            q     <= RESET_VALUE;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with freeze/flush. Define PIPE_SKID_EN to add a
// skid entry so in_ready is driven from registers only (no out_ready path).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 200,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             accept;
    logic             consume;
    logic             main_load;
    logic             main_drop;
    logic [WIDTH-1:0] main_d;

    // Flush wins over stall inside the slots, so stall only needs to gate load/drop.
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready && !stall;

`ifdef PIPE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_q;
    logic             skid_load;
    logic             skid_drop;

    assign in_ready = !skid_valid && !stall && !flush;

    // Skid is always younger than main, so a consume refills main from skid first.
    assign main_load = (consume && skid_valid) || (accept && (!out_valid || consume));
    assign main_d    = skid_valid ? skid_q : in_data;
    assign main_drop = consume && !skid_valid && !accept;
    assign skid_load = accept && out_valid && !consume;
    assign skid_drop = consume && skid_valid;

    pipe_skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .load  (skid_load),
        .drop  (skid_drop),
        .d     (in_data),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign occupancy = OCC_W'(out_valid) + OCC_W'(skid_valid);
`else
    assign in_ready  = !stall && !flush && (!out_valid || out_ready);
    assign main_load = accept;
    assign main_d    = in_data;
    assign main_drop = consume && !accept;
    assign occupancy = {1'b0, out_valid};
`endif

    pipe_skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .load  (main_load),
        .drop  (main_drop),
        .d     (main_d),
        .valid (out_valid),
        .q     (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expectations follow PIPE_SKID_EN when defined.
module tb_pipe_stage_reg;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hC3;

    logic         clk = 1'b0;
    logic         reset, stall, flush, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] occ);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"}, 32'(out_data), 32'(d));
        chk({tag, ".occ"}, 32'(occupancy), 32'(occ));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        tick(); tick();
        chk_out("reset", 1'b0, RV, 2'd0);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        chk_out("idle", 1'b0, RV, 2'd0);

        // streaming at full rate
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        #1 chk("stream.ready", 32'(in_ready), 32'd1);
        tick(); chk_out("s1", 1'b1, 8'h01, 2'd1);
        in_data = 8'h02;
        tick(); chk_out("s2", 1'b1, 8'h02, 2'd1);
        in_data = 8'h03;
        tick(); chk_out("s3", 1'b1, 8'h03, 2'd1);
        in_valid = 1'b0;
        tick(); chk_out("drain", 1'b0, 8'h03, 2'd0);

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10;
        tick(); chk_out("bp0", 1'b1, 8'h10, 2'd1);
        in_data = 8'h11;
`ifdef PIPE_SKID_EN
        #1 chk("bp.skid_ready", 32'(in_ready), 32'd1);
        tick(); chk_out("bp1", 1'b1, 8'h10, 2'd2);
        in_data = 8'h12;
        chk("bp.full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1 chk("bp.no_comb_path", 32'(in_ready), 32'd0);
        tick(); chk_out("bp_r1", 1'b1, 8'h11, 2'd1);
        chk("bp.ready_after", 32'(in_ready), 32'd1);
        tick(); chk_out("bp_r2", 1'b1, 8'h12, 2'd1);
`else
        #1 chk("bp.ready", 32'(in_ready), 32'd0);
        tick(); chk_out("bp1", 1'b1, 8'h10, 2'd1);
        out_ready = 1'b1;
        #1 chk("bp.comb_ready", 32'(in_ready), 32'd1);
        tick(); chk_out("bp_r1", 1'b1, 8'h11, 2'd1);
        in_data = 8'h12;
        tick(); chk_out("bp_r2", 1'b1, 8'h12, 2'd1);
`endif
        in_valid = 1'b0;
        tick(); chk_out("bp_drain", 1'b0, 8'h12, 2'd0);

        // stall freezes everything
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        tick(); chk_out("st0", 1'b1, 8'h55, 2'd1);
        in_data = 8'h56; out_ready = 1'b1; stall = 1'b1;
        #1 chk("stall.ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("stall", 1'b1, 8'h55, 2'd1);
        end
        stall = 1'b0; in_valid = 1'b0;
        #1 chk_out("unstall", 1'b1, 8'h55, 2'd1);
        tick(); chk_out("st_drain", 1'b0, 8'h55, 2'd0);

        // flush with stall and a concurrent offer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h30;
        tick();
        in_data = 8'h31;
        tick();
`ifdef PIPE_SKID_EN
        chk("fl.pre_occ", 32'(occupancy), 32'd2);
`else
        chk("fl.pre_occ", 32'(occupancy), 32'd1);
`endif
        flush = 1'b1; stall = 1'b1; in_data = 8'h77;
        #1 chk("flush.ready", 32'(in_ready), 32'd0);
        tick(); chk_out("flush", 1'b0, RV, 2'd0);
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); chk_out("post_flush", 1'b0, RV, 2'd0);

        // accept and consume in the same cycle at occupancy 1
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h1F;
        tick(); chk_out("ac0", 1'b1, 8'h1F, 2'd1);
        in_data = 8'h20; out_ready = 1'b1;
        tick(); chk_out("ac1", 1'b1, 8'h20, 2'd1);

        // reset mid-stream drops the held entry
        in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
        tick(); chk_out("mid_reset", 1'b0, RV, 2'd0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
